// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR upstream driver.
// State encoding, tap/word widths and coefficient word count.
package fir_pkg;

  function automatic int ceil_div(int a, int b);
    return (a + b - 1) / b;
  endfunction

  localparam int TAP_SIZE    = 2;
  localparam int NBR_OF_TAPS = 8;
  localparam int SAMPLE_W    = 3 * TAP_SIZE;
  localparam int COEF_WORDS  = ceil_div(NBR_OF_TAPS, 3);
  localparam int ADDR_W      = $clog2(NBR_OF_TAPS);
  localparam int WIDX_W      =
    (COEF_WORDS > 1) ? $clog2(COEF_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LOAD   = 2'b01,
    GAP    = 2'b10,
    STREAM = 2'b11
  } state_t;

  typedef logic signed [TAP_SIZE-1:0] tap_t;
  typedef logic [SAMPLE_W-1:0]        word_t;

endpackage

// File: rtl/fir_driver_if.sv
// Upstream sample stream handshake (data/valid/ready).
// master drives data+valid, slave returns ready.
interface fir_driver_if;
  import fir_pkg::*;

  word_t s_tdata;
  logic  s_tvalid;
  logic  s_tready;

  modport master (
    output s_tdata,
    output s_tvalid,
    input  s_tready
  );

  modport slave (
    input  s_tdata,
    input  s_tvalid,
    output s_tready
  );

endinterface

// File: rtl/fir_coef_bank.sv
// Shadow tap bank: write port plus packed 3-tap word read.
// Ports: clk, reset(n), wr_en/wr_addr/wr_data, rd_idx -> rd_word.
module fir_coef_bank
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  tap_t              wr_data,
  input  logic [WIDX_W-1:0] rd_idx,
  output word_t             rd_word
);

  tap_t  taps  [NBR_OF_TAPS];
  tap_t  slots [3*COEF_WORDS];
  word_t words [COEF_WORDS];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NBR_OF_TAPS; i++)
        taps[i] <= (i % 2 == 0) ? tap_t'(1) : tap_t'(0);
    end else if (wr_en &&
                 (int'(wr_addr) < NBR_OF_TAPS)) begin
      taps[wr_addr] <= wr_data;
    end
  end

  // Slots past the last tap pad the final word with 00.
  for (genvar s = 0; s < 3*COEF_WORDS; s++) begin : g_slot
    if (s < NBR_OF_TAPS) begin : g_tap
      assign slots[s] = taps[s];
    end else begin : g_pad
      assign slots[s] = '0;
    end
  end

  // Lowest tap index sits in the MSBs; plain concatenation.
  for (genvar k = 0; k < COEF_WORDS; k++) begin : g_word
    assign words[k] = {slots[3*k],
                       slots[3*k+1],
                       slots[3*k+2]};
  end

  assign rd_word = words[rd_idx];

endmodule

// File: rtl/fir_driver.sv
// Upstream driver for the FIR: coefficient upload, guard, stream.
// Ports: clk, reset(n), coef write, load_req, up stream, FIR outs.
module fir_driver
  import fir_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              coef_wr_en,
  input  logic [ADDR_W-1:0] coef_wr_addr,
  input  tap_t              coef_wr_data,
  input  logic              load_req,
  fir_driver_if.slave       up,
  output word_t             fir_x_n,
  output logic              fir_tvalid,
  output logic              fir_set_coeffs,
  output logic              busy,
  output logic              load_done
);

  localparam logic [WIDX_W-1:0] LAST =
    WIDX_W'(COEF_WORDS - 1);

  state_t            state_q;
  state_t            state_d;
  logic [WIDX_W-1:0] w_q;
  logic [WIDX_W-1:0] w_d;
  logic              pending_q;
  logic              coef_valid_q;
  logic              ready;
  logic              accept;
  logic              bank_wr;
  word_t             rd_word;

  word_t             x_d;
  logic              tv_d;
  logic              set_d;
  logic              busy_d;
  logic              done_d;

  assign ready  = (state_q == STREAM) &&
                  !pending_q && coef_valid_q;
  assign accept = ready && up.s_tvalid;
  assign up.s_tready = ready;

  // Block writes on the edge into LOAD as well, so word 0
  // and the later words come from the same image.
  assign bank_wr = coef_wr_en &&
                   (state_q != LOAD) &&
                   (state_d != LOAD);

  fir_coef_bank u_bank (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bank_wr),
    .wr_addr (coef_wr_addr),
    .wr_data (coef_wr_data),
    .rd_idx  (w_d),
    .rd_word (rd_word)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == IDLE):
        if (pending_q || load_req) state_d = LOAD;
      (state_q == LOAD):
        if (w_q == LAST) state_d = GAP;
      (state_q == GAP):
        state_d = (pending_q || load_req) ? LOAD : STREAM;
      (state_q == STREAM):
        if (pending_q) state_d = GAP;
      default:
        state_d = IDLE;
    endcase
    w_d = '0;
    if (state_d == LOAD && state_q == LOAD)
      w_d = w_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pending_q    <= 1'b0;
      coef_valid_q <= 1'b0;
    end else begin
      if (state_d == LOAD && state_q != LOAD)
        pending_q <= 1'b0;
      else if (load_req)
        pending_q <= 1'b1;
      if (state_q == GAP)
        coef_valid_q <= 1'b1;
    end
  end

  // Outputs are looked up from the next state so the
  // registered values line up with the state they belong to.
  always_comb begin
    x_d    = '0;
    tv_d   = 1'b0;
    set_d  = 1'b0;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (1'b1)
      (state_d == LOAD): begin
        x_d    = rd_word;
        set_d  = 1'b1;
        busy_d = 1'b1;
        done_d = (w_d == LAST);
      end
      (state_d == GAP): begin
        busy_d = 1'b1;
      end
      accept: begin
        x_d  = up.s_tdata;
        tv_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fir_x_n        <= '0;
      fir_tvalid     <= 1'b0;
      fir_set_coeffs <= 1'b0;
      busy           <= 1'b0;
      load_done      <= 1'b0;
    end else begin
      fir_x_n        <= x_d;
      fir_tvalid     <= tv_d;
      fir_set_coeffs <= set_d;
      busy           <= busy_d;
      load_done      <= done_d;
    end
  end

endmodule

// File: doc/fir_driver.md
Name: fir_driver

Overview:
- Upstream-side driver for the FIR core. Holds a shadow bank of 2-bit signed tap coefficients and uploads them to the FIR as packed 6-bit words on x_n with set_coeffs asserted.
- Then forwards an upstream valid/ready sample stream into the FIR's x_n/tvalid inputs.
- Sits between the chip-level I/O decode and the FIR instance.
- Guarantees a legal drive sequence: upload, a guard cycle, then streaming.

Parameters:
- TAP_SIZE, 2, width of one signed coefficient.
- NBR_OF_TAPS, 8, number of coefficients in the shadow bank.
- SAMPLE_W, 6, sample and packed-word width; must equal 3*TAP_SIZE.
- COEF_WORDS, 3, upload word count, ceil(NBR_OF_TAPS/3).

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising edge of clk).
- coef_wr_en  in  1  write strobe into shadow bank.
- coef_wr_addr  in  3  tap index 0..NBR_OF_TAPS-1.
- coef_wr_data  in  2  signed tap value.
- load_req  in  1  request coefficient upload (level or pulse; captured as pending).
- s_tdata  in  6  signed upstream sample.
- s_tvalid  in  1  upstream sample valid.
- s_tready  out  1  sample accepted when s_tvalid and s_tready are both 1.
- fir_x_n  out  6  to FIR x_n: packed coefficients in LOAD, samples in STREAM.
- fir_tvalid  out  1  to FIR s_axis_fir_tvalid.
- fir_set_coeffs  out  1  to FIR s_set_coeffs.
- busy  out  1  1 while in LOAD or GAP.
- load_done  out  1  one-cycle pulse on the last LOAD cycle.

Behaviour:
- Reset (reset=0 at an edge):
  - state IDLE; all outputs 0 (s_tready, fir_x_n, fir_tvalid, fir_set_coeffs, busy, load_done).
  - pending cleared; coef_valid cleared.
  - shadow taps reset to tap[i] = 1 for even i, 0 for odd i.
- All FIR-facing outputs are registered; s_tready is combinational from state and pending only.
- Shadow writes:
  - Applied at the edge when coef_wr_en=1 and addr<NBR_OF_TAPS.
  - Out-of-range addr is ignored.
  - Writes while in LOAD are ignored; the upload image is never torn.
- pending is set by load_req=1 and cleared when LOAD is entered.
- States: IDLE, LOAD, GAP, STREAM.
- IDLE:
  - s_tready=0.
  - Next state LOAD if pending or load_req, else stay.
  - Samples are never accepted before the first completed upload.
- LOAD:
  - Exactly COEF_WORDS consecutive cycles, word counter w=0..COEF_WORDS-1.
  - fir_set_coeffs=1, fir_tvalid=0, busy=1.
  - fir_x_n = {tap[3w], tap[3w+1], tap[3w+2]}, MSB first; indices >= NBR_OF_TAPS pack as 00.
  - load_done=1 on w=COEF_WORDS-1.
  - Next state GAP.
- GAP:
  - One cycle, all FIR outputs 0, busy=1, so the FIR returns to its idle state.
  - coef_valid set to 1.
  - Next state LOAD if pending, else STREAM.
- STREAM:
  - s_tready = !pending.
  - Accepted sample at edge k appears on fir_x_n with fir_tvalid=1 in cycle k+1 (latency 1).
  - Cycle with no accept: fir_tvalid=0 and fir_x_n=0.
  - load_req in STREAM: s_tready drops the next cycle. The in-flight sample, if any, is still presented. Then go to GAP-free LOAD only after one cycle of fir_tvalid=0 (insert the GAP state before LOAD).
  - Transition order is STREAM -> GAP -> LOAD -> GAP -> STREAM.
- Simultaneous events:
  - load_req and s_tvalid in the same STREAM cycle: the sample is accepted, because s_tready is evaluated from pending before it sets.
  - load_req during LOAD or GAP: sets pending, causing a second upload after GAP.
- Reset mid-LOAD or mid-STREAM: the next cycle shows all outputs 0, state IDLE, and coef_valid=0. A fresh upload is required.
- Width rules:
  - Data is passed through unmodified, with no arithmetic on samples.
  - Tap packing is a pure bit concatenation, with no sign extension.

Decomposition:
- Shared package fir_pkg holds:
  - state encoding constants IDLE=2'b00, LOAD=2'b01, GAP=2'b10, STREAM=2'b11;
  - TAP_SIZE, SAMPLE_W, NBR_OF_TAPS defaults;
  - COEF_WORDS derivation.
- One natural sub-module: fir_coef_bank, holding the shadow registers, write port, and combinational packed-word read by word index.
- The FSM, pending flag and output registers stay in fir_driver.

Test Plan:
- Reset then s_tvalid=1, s_tdata=6'h05 for 10 cycles, no load_req -> s_tready=0 throughout; fir_tvalid=0, fir_set_coeffs=0.
- Reset, load_req pulse -> 3 cycles of fir_set_coeffs=1 with fir_x_n = 6'b010001, 6'b000100, 6'b010000 (default taps 1,0,1,0,1,0,1,0, padding 00); load_done on the 3rd cycle; one GAP cycle; then s_tready=1.
- Write taps 0..7 = 3,2,1,0,3,2,1,0, then load_req -> words 6'b111001, 6'b001110, 6'b010000.
- In STREAM, samples 6'h01, 6'h3F, 6'h20 on consecutive cycles -> same values on fir_x_n with fir_tvalid=1, each one cycle later; a bubble in s_tvalid gives fir_tvalid=0 and fir_x_n=0.
- In STREAM, load_req coincident with sample 6'h0A -> 6'h0A is forwarded; s_tready=0 next; fir_tvalid=0 for the GAP cycle; 3 LOAD cycles; GAP; streaming resumes.
- reset=0 during the 2nd LOAD word -> the next cycle shows all outputs 0; with no new load_req, s_tready stays 0.
